// File: rtl/axis_dac_burst_mapper.sv
// axis_dac_burst_mapper
//   Generates and maps DAC codes for CHANNELS outputs. Each channel selects
//   between AXI-Stream passthrough, PRBS-BPSK burst, burst-gate square and a
//   constant level, scaled by a saturated per-channel amplitude. A built-in
//   PRBS burst sequencer (IDLE/BURST/GAP) drives the burst channels.
//
// Ports
//   aclk, aresetn      clock, synchronous active-low reset
//   s_axis_tdata/valid stream input, one 16-bit lane per channel (low W bits used)
//   s_axis_tready      high whenever out of reset (no backpressure)
//   cfg_mode           2 bits per channel: 00 stream, 01 PRBS, 10 square, 11 const
//   cfg_amp            W bits per channel, unsigned magnitude
//   cfg_ctrl           [7:0] div, [10:8] rep, [13:11] ord, [14] en, [15] srst
//   m_axis_tdata/valid registered DAC codes, channel c at [W*c +: W]
//   tx_flag_o, sym_o   registered burst flag and current PRBS chip
module axis_dac_burst_mapper #(
  parameter int DAC_DATA_WIDTH   = 14,
  parameter int CHANNELS         = 2,
  parameter int AXIS_TDATA_WIDTH = 16 * CHANNELS
) (
  input  logic                               aclk,
  input  logic                               aresetn,
  input  logic [AXIS_TDATA_WIDTH-1:0]        s_axis_tdata,
  input  logic                               s_axis_tvalid,
  output logic                               s_axis_tready,
  input  logic [2*CHANNELS-1:0]              cfg_mode,
  input  logic [DAC_DATA_WIDTH*CHANNELS-1:0] cfg_amp,
  input  logic [31:0]                        cfg_ctrl,
  output logic [DAC_DATA_WIDTH*CHANNELS-1:0] m_axis_tdata,
  output logic                               m_axis_tvalid,
  output logic                               tx_flag_o,
  output logic                               sym_o
);

  localparam int W = DAC_DATA_WIDTH;
  localparam int LFSR_W = 10;
  localparam logic [W-1:0] AMP_MAX  = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] MIDSCALE = {1'b0, {(W-1){1'b1}}};

  typedef enum logic [1:0] {IDLE, BURST, GAP} state_t;

  function automatic logic [W-1:0] sat_amp(input logic [W-1:0] amp);
    return (amp > AMP_MAX) ? AMP_MAX : amp;
  endfunction

  function automatic logic [W-1:0] to_code(input logic signed [W-1:0] v);
    return {v[W-1], ~v[W-2:0]};
  endfunction

  function automatic logic signed [W-1:0] chan_value(
    input logic [1:0]          mode,
    input logic [W-1:0]        amp,
    input logic signed [W-1:0] lane,
    input logic                vld,
    input logic                flag,
    input logic                sym
  );
    logic signed [W:0]   pos_w;
    logic signed [W:0]   neg_w;
    logic signed [W-1:0] pos_v;
    logic signed [W-1:0] neg_v;
    // +a/-a are formed one bit wider so negating the clipped magnitude
    // cannot overflow before truncation back to W bits.
    pos_w = signed'({1'b0, sat_amp(amp)});
    neg_w = -pos_w;
    pos_v = signed'(pos_w[W-1:0]);
    neg_v = signed'(neg_w[W-1:0]);
    case (mode)
      2'b00:   chan_value = vld ? lane : '0;
      2'b01:   chan_value = flag ? (sym ? pos_v : neg_v) : '0;
      2'b10:   chan_value = flag ? pos_v : neg_v;
      default: chan_value = pos_v;
    endcase
  endfunction

  logic [7:0] div_in;
  logic [2:0] rep_in;
  logic [2:0] ord_in;
  logic       en;
  logic       srst;
  logic       unused_bits;

  assign div_in      = cfg_ctrl[7:0];
  assign rep_in      = cfg_ctrl[10:8];
  assign ord_in      = cfg_ctrl[13:11];
  assign en          = cfg_ctrl[14];
  assign srst        = cfg_ctrl[15];
  assign unused_bits = ^{cfg_ctrl[31:16], s_axis_tdata};

  state_t            state, state_n;
  logic [LFSR_W-1:0] lfsr, lfsr_n;
  logic [7:0]        div_cnt, div_cnt_n;
  logic [9:0]        chip_cnt, chip_cnt_n;
  logic [2:0]        rep_cnt, rep_cnt_n;
  logic [7:0]        div_l, div_l_n;
  logic [2:0]        rep_l, rep_l_n;
  logic [2:0]        ord_l, ord_l_n;
  logic              ready;
  logic              fb;
  logic              advance;
  logic              chip_last;
  logic [9:0]        period_last;
  logic              burst_n;
  logic              sym_n;

  // Index of the last chip of one PRBS period: 2^N - 2. Wraps correctly
  // in 10 bits for N = 10.
  assign period_last = (10'd1 << ({1'b0, ord_l} + 4'd3)) - 10'd2;
  assign advance     = (div_cnt == div_l);
  assign chip_last   = (chip_cnt == period_last);

  always_comb begin
    fb = 1'b0;
    case (ord_l)
      3'd0:    fb = lfsr[2] ^ lfsr[1];
      3'd1:    fb = lfsr[3] ^ lfsr[2];
      3'd2:    fb = lfsr[4] ^ lfsr[2];
      3'd3:    fb = lfsr[5] ^ lfsr[4];
      3'd4:    fb = lfsr[6] ^ lfsr[5];
      3'd5:    fb = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
      3'd6:    fb = lfsr[8] ^ lfsr[4];
      default: fb = lfsr[9] ^ lfsr[6];
    endcase
  end

  always_comb begin
    state_n    = state;
    lfsr_n     = lfsr;
    div_cnt_n  = div_cnt;
    chip_cnt_n = chip_cnt;
    rep_cnt_n  = rep_cnt;
    div_l_n    = div_l;
    rep_l_n    = rep_l;
    ord_l_n    = ord_l;
    if (srst || !en) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE: begin
          state_n    = BURST;
          lfsr_n     = '1;
          div_cnt_n  = '0;
          chip_cnt_n = '0;
          rep_cnt_n  = '0;
          div_l_n    = div_in;
          rep_l_n    = rep_in;
          ord_l_n    = ord_in;
        end
        BURST: begin
          div_cnt_n = advance ? 8'd0 : div_cnt + 8'd1;
          if (advance) begin
            lfsr_n = {lfsr[LFSR_W-2:0], fb};
            if (chip_last) begin
              chip_cnt_n = '0;
              if (rep_cnt == rep_l) begin
                state_n   = GAP;
                rep_cnt_n = '0;
              end else begin
                rep_cnt_n = rep_cnt + 3'd1;
              end
            end else begin
              chip_cnt_n = chip_cnt + 10'd1;
            end
          end
        end
        GAP: begin
          div_cnt_n = advance ? 8'd0 : div_cnt + 8'd1;
          if (advance) begin
            if (chip_last) begin
              // New burst: reseed and pick up any config written meanwhile.
              state_n    = BURST;
              lfsr_n     = '1;
              div_cnt_n  = '0;
              chip_cnt_n = '0;
              rep_cnt_n  = '0;
              div_l_n    = div_in;
              rep_l_n    = rep_in;
              ord_l_n    = ord_in;
            end else begin
              chip_cnt_n = chip_cnt + 10'd1;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // The flag/chip registers follow the next state so they line up with it.
  assign burst_n = (state_n == BURST);
  assign sym_n   = burst_n & lfsr_n[{1'b0, ord_l_n} + 4'd2];

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state     <= IDLE;
      lfsr      <= '1;
      div_cnt   <= '0;
      chip_cnt  <= '0;
      rep_cnt   <= '0;
      div_l     <= '0;
      rep_l     <= '0;
      ord_l     <= '0;
      tx_flag_o <= 1'b0;
      sym_o     <= 1'b0;
      ready     <= 1'b0;
    end else begin
      state     <= state_n;
      lfsr      <= lfsr_n;
      div_cnt   <= div_cnt_n;
      chip_cnt  <= chip_cnt_n;
      rep_cnt   <= rep_cnt_n;
      div_l     <= div_l_n;
      rep_l     <= rep_l_n;
      ord_l     <= ord_l_n;
      tx_flag_o <= burst_n;
      sym_o     <= sym_n;
      ready     <= 1'b1;
    end
  end

  assign s_axis_tready = ready;
  assign m_axis_tvalid = ready;

  // Stage p0: stream lanes captured alongside the generator registers
  logic signed [W-1:0] lane_p0 [CHANNELS];
  logic                vld_p0;

  always_ff @(posedge aclk) begin
    for (int c = 0; c < CHANNELS; c++) begin
      lane_p0[c] <= signed'(s_axis_tdata[16*c +: W]);
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      vld_p0 <= 1'b0;
    end else begin
      vld_p0 <= s_axis_tvalid & ready;
    end
  end

  // Stage p1: per-channel value selection and offset-binary code register
  logic [W*CHANNELS-1:0] code_p1;

  always_comb begin
    code_p1 = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      code_p1[W*c +: W] = to_code(chan_value(cfg_mode[2*c +: 2], cfg_amp[W*c +: W],
                                             lane_p0[c], vld_p0, tx_flag_o, sym_o));
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      m_axis_tdata <= {CHANNELS{MIDSCALE}};
    end else begin
      m_axis_tdata <= code_p1;
    end
  end

endmodule

// File: doc/axis_dac_burst_mapper.md
# axis_dac_burst_mapper

Parametrised multi-channel successor to the Red Pitaya DAC sample path: it generates and maps DAC codes for CHANNELS outputs, each independently selectable between AXI-Stream passthrough, PRBS-BPSK burst, burst-gate square and constant level, with programmable amplitude and saturation. It contains its own PRBS burst sequencer, with selectable order, chip divider and repetition count, plus an IDLE/BURST/GAP state machine. It sits between the stream source and the existing ODDR/interleaver output stage and delivers one registered code per channel per clock.

## Interface
- DAC_DATA_WIDTH, 14, DAC code width W per channel
- CHANNELS, 2, number of output channels
- AXIS_TDATA_WIDTH, 16*CHANNELS, input stream width; one 16-bit lane per channel, low W bits two's complement
- aclk  in  1  single clock, all logic rising-edge
- aresetn  in  1  synchronous, active-low reset
- s_axis_tdata  in  AXIS_TDATA_WIDTH  stream samples, lane c = bits [16c+W-1:16c]
- s_axis_tvalid  in  1  stream valid
- s_axis_tready  out  1  stream ready
- cfg_mode  in  2*CHANNELS  per channel: 00 stream, 01 PRBS-BPSK, 10 square, 11 constant
- cfg_amp  in  W*CHANNELS  per-channel amplitude, unsigned magnitude
- cfg_ctrl  in  32  [7:0] div, [10:8] rep, [13:11] ord, [14] en, [15] srst
- m_axis_tdata  out  W*CHANNELS  DAC codes, channel c at [Wc+W-1:Wc]
- m_axis_tvalid  out  1  output valid
- tx_flag_o  out  1  high during BURST
- sym_o  out  1  current PRBS chip

## Operation
- Code conversion: two's-complement value v (W bits) maps to code {v[W-1], ~v[W-2:0]}. Midscale (v=0) is 0x1FFF for W=14.
- Amplitude: a = min(cfg_amp_c, 2^(W-1)-1). +a and -a are computed at W+1 bits, then truncated to W bits; no overflow is possible.
- Channel value:
  - stream: lane sample when s_axis_tvalid=1, otherwise 0.
  - PRBS: tx_flag_o ? (sym_o ? +a : -a) : 0.
  - square: tx_flag_o ? +a : -a.
  - constant: +a.
- s_axis_tready=1 at all times except during reset. The block never applies backpressure.
- LFSR: order N = ord+3 (3..10). The LFSR is a Fibonacci register s[N-1:0] with seed all-ones.
  - sym = s[N-1].
  - fb = XOR of taps.
  - Shift: s <= {s[N-2:0], fb}.
  - Taps (1-indexed): 3:(3,2), 4:(4,3), 5:(5,3), 6:(6,5), 7:(7,6), 8:(8,6,5,4), 9:(9,5), 10:(10,7).
- Chip divider: a counter runs 0..div. A chip advance occurs when the count reaches div, so each chip lasts div+1 cycles. The LFSR steps only on chip advance, during BURST.
- FSM states IDLE, BURST, GAP:
  - IDLE->BURST: when en=1 and srst=0. On this transition, div, rep and ord are latched, the LFSR is reseeded and counters are cleared.
  - BURST->GAP: after (rep+1)*(2^N-1) chips.
  - GAP->BURST: after 2^N-1 chips. The LFSR is reseeded and config is re-latched.
  - Any state->IDLE: when en=0 or srst=1. srst dominates en.
- Config changes mid-burst take effect at the next BURST entry.

## Timing
- Reset values (aresetn=0 at a clock edge):
  - m_axis_tdata = midscale on all channels.
  - m_axis_tvalid=0, tx_flag_o=0, sym_o=0, s_axis_tready=0.
  - State IDLE, LFSR seeded.
- s_axis_tready and m_axis_tvalid rise on the first clock after aresetn is sampled high, then stay high.
- Stream latency: sample accepted at edge n appears on m_axis_tdata after edge n+1.
- Generator latency: tx_flag_o and sym_o are registered. m_axis_tdata reflects them one cycle later.
- Burst start: tx_flag_o rises on the clock after en is sampled high in IDLE, with sym_o = 1 (seed MSB).
- en=0 mid-burst: at the next clock, tx_flag_o=0 and sym_o=0. The PRBS channel outputs midscale one cycle later.
- Reset mid-burst overrides everything at the same edge.
- cfg_mode/cfg_amp changes take effect at the next edge (one-cycle output latency).

## Test plan
- Reset: hold aresetn low 5 cycles with tvalid=1 and en=1 -> all codes 0x1FFF, tvalid=0, flag=0. After release, tready=1 and tvalid=1 after one cycle.
- Stream, mode 00: lane0 samples 0x0000, 0x1FFF, 0x2000 -> codes 0x1FFF, 0x0000, 0x3FFF, each one cycle later. tvalid=0 -> 0x1FFF.
- PRBS, ord=0, div=0, rep=0, amp=0x1000 -> flag high 7 cycles then low 7 cycles, repeating. sym_o = 1,1,1,0,0,1,0. Codes are 0x0FFF (+) and 0x2FFF (-); midscale during GAP.
- Divider/rep, div=3, rep=1, ord=0 -> each chip lasts 4 cycles, burst 56 cycles, gap 28 cycles. A div change mid-burst takes effect only on the next burst.
- Saturation, mode 10, amp=0x3FFF -> clipped to 8191. Codes are 0x0000 during burst and 0x3FFE during gap.
- Abort: drop en at chip 4 of a burst -> flag=0 next cycle, PRBS channel at midscale. Re-enable -> sym_o restarts at 1,1,1,0,...
